match_referee: RTL and testbench

Downstream observer of `scoring`. It runs a fixed-length match of `NUM_ROUNDS` rounds on request and taps the same `action_A`/`action_B` pair that `scoring` consumes, plus the `score_A`/`score_B` totals it produces. At match end it reports per-match points, the winner, cooperation/defection statistics and the first defector. It also cross-checks `scoring`'s score deltas against its own payoff tally. `scoring` free-runs, so `match_referee` works from score deltas and needs no control over `scoring`.

---
 rtl/match_referee.sv | 214 +++++++++++++++++++++
 tb/tb_match_referee.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_referee.sv
// Match referee: observes the action pair and running scores fed to/produced by
// the free-running scorer, runs a fixed-length match and reports per-match results.
module match_referee #(
    parameter int NUM_ROUNDS = 10,
    parameter int RW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          action_A,
    input  logic          action_B,
    input  logic [31:0]   score_A,
    input  logic [31:0]   score_B,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] round_idx,
    output logic [31:0]   match_A,
    output logic [31:0]   match_B,
    output logic [1:0]    winner,
    output logic [RW-1:0] coop_both,
    output logic [RW-1:0] defect_both,
    output logic [1:0]    first_defect,
    output logic          score_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

    function automatic logic [31:0] payoff_a(input logic a, input logic b);
        case ({a, b})
            2'b00:   payoff_a = 32'd5;
            2'b01:   payoff_a = 32'd1;
            2'b10:   payoff_a = 32'd4;
            default: payoff_a = 32'd2;
        endcase
    endfunction

    function automatic logic [31:0] payoff_b(input logic a, input logic b);
        case ({a, b})
            2'b00:   payoff_b = 32'd5;
            2'b01:   payoff_b = 32'd4;
            2'b10:   payoff_b = 32'd1;
            default: payoff_b = 32'd2;
        endcase
    endfunction

    function automatic logic [1:0] pick_winner(input logic [31:0] pa, input logic [31:0] pb);
        if (pa > pb)
            pick_winner = 2'b01;
        else if (pb > pa)
            pick_winner = 2'b10;
        else
            pick_winner = 2'b00;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [31:0]   tally_a_q, tally_a_d;
    logic [31:0]   tally_b_q, tally_b_d;
    logic [31:0]   base_a_q, base_a_d;
    logic [31:0]   base_b_q, base_b_d;
    logic [RW-1:0] coop_q, coop_d;
    logic [RW-1:0] defect_q, defect_d;
    logic [1:0]    first_q, first_d;
    logic          err_q, err_d;
    logic [31:0]   match_a_q, match_a_d;
    logic [31:0]   match_b_q, match_b_d;
    logic [1:0]    winner_q, winner_d;
    logic          done_q, done_d;

    logic [31:0] delta_a;
    logic [31:0] delta_b;
    logic        pair_coop;
    logic        pair_defect;

    // Modular subtraction makes a wrap of the scorer's totals invisible.
    assign delta_a     = score_A - base_a_q;
    assign delta_b     = score_B - base_b_q;
    assign pair_coop   = ~action_A & ~action_B;
    assign pair_defect =  action_A &  action_B;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        tally_a_d = tally_a_q;
        tally_b_d = tally_b_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        coop_d    = coop_q;
        defect_d  = defect_q;
        first_d   = first_q;
        err_d     = err_q;
        match_a_d = match_a_q;
        match_b_d = match_b_q;
        winner_d  = winner_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                round_d   = '0;
                tally_a_d = '0;
                tally_b_d = '0;
                coop_d    = '0;
                defect_d  = '0;
                first_d   = 2'b00;
                err_d     = 1'b0;
                if (start)
                    state_d = S_PLAY;
            end

            S_PLAY: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    round_d   = '0;
                    tally_a_d = '0;
                    tally_b_d = '0;
                    coop_d    = '0;
                    defect_d  = '0;
                    first_d   = 2'b00;
                    err_d     = 1'b0;
                end else begin
                    // Scores seen on the first round edge exclude that round.
                    if (round_q == '0) begin
                        base_a_d = score_A;
                        base_b_d = score_B;
                    end
                    round_d   = round_q + 1'b1;
                    tally_a_d = tally_a_q + payoff_a(action_A, action_B);
                    tally_b_d = tally_b_q + payoff_b(action_A, action_B);
                    if (pair_coop)
                        coop_d = coop_q + 1'b1;
                    if (pair_defect)
                        defect_d = defect_q + 1'b1;
                    // Bit 0 flags A, bit 1 flags B.
                    if (first_q == 2'b00)
                        first_d = {action_B, action_A};
                    if (round_d == LAST_ROUND)
                        state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                state_d = S_IDLE;
                if (abort) begin
                    round_d   = '0;
                    tally_a_d = '0;
                    tally_b_d = '0;
                    coop_d    = '0;
                    defect_d  = '0;
                    first_d   = 2'b00;
                    err_d     = 1'b0;
                end else begin
                    match_a_d = delta_a;
                    match_b_d = delta_b;
                    winner_d  = pick_winner(delta_a, delta_b);
                    err_d     = err_q | (delta_a != tally_a_q) | (delta_b != tally_b_q);
                    done_d    = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            round_q   <= '0;
            tally_a_q <= '0;
            tally_b_q <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            coop_q    <= '0;
            defect_q  <= '0;
            first_q   <= 2'b00;
            err_q     <= 1'b0;
            match_a_q <= '0;
            match_b_q <= '0;
            winner_q  <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            tally_a_q <= tally_a_d;
            tally_b_q <= tally_b_d;
            base_a_q  <= base_a_d;
            base_b_q  <= base_b_d;
            coop_q    <= coop_d;
            defect_q  <= defect_d;
            first_q   <= first_d;
            err_q     <= err_d;
            match_a_q <= match_a_d;
            match_b_q <= match_b_d;
            winner_q  <= winner_d;
            done_q    <= done_d;
        end
    end

    assign busy         = (state_q == S_PLAY) || (state_q == S_SETTLE);
    assign done         = done_q;
    assign round_idx    = round_q;
    assign match_A      = match_a_q;
    assign match_B      = match_b_q;
    assign winner       = winner_q;
    assign coop_both    = coop_q;
    assign defect_both  = defect_q;
    assign first_defect = first_q;
    assign score_err    = err_q;

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee: table of 4-round matches plus hand-written
// sequences for abort, asynchronous reset and start handling.
module tb_match_referee;

    localparam int N  = 4;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          action_A = 1'b0;
    logic          action_B = 1'b0;
    logic [31:0]   score_A;
    logic [31:0]   score_B;
    logic          busy;
    logic          done;
    logic [RW-1:0] round_idx;
    logic [31:0]   match_A;
    logic [31:0]   match_B;
    logic [1:0]    winner;
    logic [RW-1:0] coop_both;
    logic [RW-1:0] defect_both;
    logic [1:0]    first_defect;
    logic          score_err;

    match_referee #(.NUM_ROUNDS(N), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .action_A(action_A), .action_B(action_B),
        .score_A(score_A), .score_B(score_B),
        .busy(busy), .done(done), .round_idx(round_idx),
        .match_A(match_A), .match_B(match_B), .winner(winner),
        .coop_both(coop_both), .defect_both(defect_both),
        .first_defect(first_defect), .score_err(score_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream scorer: accumulates payoffs with one-cycle latency.
    logic [31:0] sbase_a = '0;
    logic [31:0] sbase_b = '0;
    logic [31:0] sacc_a = '0;
    logic [31:0] sacc_b = '0;
    logic        sc_en = 1'b0;
    int          done_cnt = 0;

    function automatic logic [31:0] pay_a(input logic a, input logic b);
        case ({a, b})
            2'b00: pay_a = 32'd5;  2'b01: pay_a = 32'd1;
            2'b10: pay_a = 32'd4;  default: pay_a = 32'd2;
        endcase
    endfunction

    function automatic logic [31:0] pay_b(input logic a, input logic b);
        case ({a, b})
            2'b00: pay_b = 32'd5;  2'b01: pay_b = 32'd4;
            2'b10: pay_b = 32'd1;  default: pay_b = 32'd2;
        endcase
    endfunction

    assign score_A = sbase_a + sacc_a;
    assign score_B = sbase_b + sacc_b;

    always @(posedge clk) begin
        if (sc_en) begin
            sacc_a <= sacc_a + pay_a(action_A, action_B);
            sacc_b <= sacc_b + pay_b(action_A, action_B);
        end
        if (done)
            done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [3:0]  act_a;
        logic [3:0]  act_b;
        logic [31:0] base_a;
        logic [31:0] base_b;
        logic        short_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [1:0]  exp_win;
        logic [15:0] exp_coop;
        logic [15:0] exp_def;
        logic [1:0]  exp_first;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        sc_en    = 1'b0;
        sbase_a  = v.base_a - sacc_a;
        sbase_b  = v.base_b - sacc_b;
        action_A = v.act_a[0];
        action_B = v.act_b[0];
        start    = 1'b1;
        tick();
        start = 1'b0;
        sc_en = 1'b1;
        chk($sformatf("v%0d busy_after_start", i), busy, 1);
        for (int r = 1; r < N; r++) begin
            tick();
            action_A = v.act_a[r];
            action_B = v.act_b[r];
            if (r == 1 && v.short_b)
                sbase_b = sbase_b - 32'd1;
        end
        tick();
        sc_en = 1'b0;
        chk($sformatf("v%0d done_early", i), done, 0);
        tick();
        chk($sformatf("v%0d done", i), done, 1);
        chk($sformatf("v%0d match_A", i), match_A, v.exp_a);
        chk($sformatf("v%0d match_B", i), match_B, v.exp_b);
        chk($sformatf("v%0d winner", i), winner, v.exp_win);
        chk($sformatf("v%0d coop_both", i), coop_both, v.exp_coop);
        chk($sformatf("v%0d defect_both", i), defect_both, v.exp_def);
        chk($sformatf("v%0d first_defect", i), first_defect, v.exp_first);
        chk($sformatf("v%0d score_err", i), score_err, v.exp_err);
        chk($sformatf("v%0d round_idx", i), round_idx, N);
        tick();
        chk($sformatf("v%0d done_pulse_end", i), done, 0);
        chk($sformatf("v%0d busy_end", i), busy, 0);
        chk($sformatf("v%0d match_A_held", i), match_A, v.exp_a);
    endtask

    initial begin
        int dc;
        //            act_a    act_b    base_a        base_b        sh  exp_a  exp_b  win    coop def first  err
        vecs[0] = '{4'b0000, 4'b0000, 32'd0,        32'd0,        0, 32'd20, 32'd20, 2'b00, 16'd4, 16'd0, 2'b00, 1'b0};
        vecs[1] = '{4'b1111, 4'b0000, 32'd0,        32'd0,        0, 32'd16, 32'd4,  2'b01, 16'd0, 16'd0, 2'b01, 1'b0};
        vecs[2] = '{4'b1111, 4'b1111, 32'hFFFFFFFE, 32'h7FFFFFFF, 0, 32'd8,  32'd8,  2'b00, 16'd0, 16'd4, 2'b11, 1'b0};
        vecs[3] = '{4'b0000, 4'b0000, 32'd100,      32'd200,      1, 32'd20, 32'd19, 2'b01, 16'd4, 16'd0, 2'b00, 1'b1};
        vecs[4] = '{4'b0011, 4'b0110, 32'd7,        32'd9,        0, 32'd12, 32'd12, 2'b00, 16'd1, 16'd1, 2'b01, 1'b0};
        vecs[5] = '{4'b1000, 4'b1010, 32'd50,       32'd60,       0, 32'd13, 32'd16, 2'b10, 16'd2, 16'd1, 2'b10, 1'b0};

        // Reset state
        #2;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset match_A", match_A, 0);
        chk("reset winner", winner, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle busy", busy, 0);
        chk("idle round_idx", round_idx, 0);

        for (int i = 0; i < 6; i++)
            run_vec(i);

        // Abort on round 3: back to IDLE, no done, previous result kept
        dc = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort pre round_idx", round_idx, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort round_idx", round_idx, 0);
        chk("abort coop_both", coop_both, 0);
        chk("abort match_A", match_A, 13);
        chk("abort match_B", match_B, 16);
        chk("abort winner", winner, 2'b10);
        tick();
        tick();
        chk("abort no done", done_cnt, dc);

        // start during PLAY ignored, start in done cycle accepted
        sc_en    = 1'b0;
        sbase_a  = 32'd0 - sacc_a;
        sbase_b  = 32'd0 - sacc_b;
        action_A = 1'b0;
        action_B = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        sc_en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sc_en = 1'b0;
        chk("ignore done_early", done, 0);
        tick();
        chk("ignore done", done, 1);
        chk("ignore match_A", match_A, 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart busy", busy, 1);
        chk("restart round_idx", round_idx, 0);
        tick();
        chk("restart playing", round_idx, 1);

        // Asynchronous reset mid-match
        #2;
        reset = 1'b1;
        #1;
        chk("areset busy", busy, 0);
        chk("areset round_idx", round_idx, 0);
        chk("areset match_A", match_A, 0);
        chk("areset match_B", match_B, 0);
        chk("areset winner", winner, 0);
        tick();
        reset = 1'b0;
        tick();

        // start with abort in IDLE: start wins; then abort in SETTLE
        dc = done_cnt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_over_abort busy", busy, 1);
        for (int r = 0; r < N; r++)
            tick();
        chk("settle pre busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("settle abort busy", busy, 0);
        chk("settle abort round_idx", round_idx, 0);
        tick();
        chk("settle abort no done", done_cnt, dc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
